// File: rtl/m68k_bus_ctrl.sv
// ============================================================================
// Module   : m68k_bus_ctrl
// Brief    : fx68k bus controller. Decodes the CPU address, drives the 4Kx16
//            synchronous RAM and an 8-bit LED register, and generates DTACKn
//            after configurable wait states and BERRn on access timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m68k_bus_ctrl #(
    parameter int          RAM_WAIT     = 1,
    parameter int          IO_WAIT      = 0,
    parameter int          BERR_TIMEOUT = 64,
    parameter logic [23:0] LED_ADDR     = 24'hFF0000
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    input  logic [23:1] cpu_a,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        dtack_n,
    output logic        berr_n,
    output logic        ram_cs_n,
    output logic [1:0]  ram_we_n,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_di,
    input  logic [15:0] ram_do,
    output logic [7:0]  leds
);

    // The RAM registers its output one clock after the chip-select pulse, so
    // the RAM path needs at least one WAIT decrement before read data is valid.
    localparam logic [3:0] C_RAM_LOAD = (RAM_WAIT == 0) ? 4'd1 : 4'(RAM_WAIT);
    localparam logic [3:0] C_IO_LOAD  = 4'(IO_WAIT);
    localparam logic [7:0] C_BERR_T   = 8'(BERR_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_WAIT   = 3'd2,
        S_ACK    = 3'd3,
        S_BERR   = 3'd4
    } state_t;

    state_t      state_q;
    logic [3:0]  wait_q;
    logic [7:0]  berr_cnt_q;
    logic        ram_rd_q;
    logic [15:0] cpu_din_q;
    logic        dtack_n_q;
    logic        berr_n_q;
    logic        ram_cs_n_q;
    logic [1:0]  ram_we_n_q;
    logic [7:0]  leds_q;

    logic        ram_hit;
    logic        led_hit;
    logic        strobe;
    logic        timeout;

    // Address decode and strobe / timeout qualifiers
    assign ram_hit = (cpu_a[23:13] == 11'd0);
    assign led_hit = ({cpu_a, 1'b0} == LED_ADDR);
    assign strobe  = ~(cpu_uds_n & cpu_lds_n);
    assign timeout = (berr_cnt_q == C_BERR_T);

    // RAM address and write data are straight pass-throughs from the CPU bus
    assign ram_addr = cpu_a[12:1];
    assign ram_di   = cpu_dout;

    assign cpu_din  = cpu_din_q;
    assign dtack_n  = dtack_n_q;
    assign berr_n   = berr_n_q;
    assign ram_cs_n = ram_cs_n_q;
    assign ram_we_n = ram_we_n_q;
    assign leds     = leds_q;

    // Bus cycle FSM: one commit per AS assertion, registered handshake outputs
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            berr_cnt_q <= 8'd0;
            ram_rd_q   <= 1'b0;
            cpu_din_q  <= 16'h0000;
            dtack_n_q  <= 1'b1;
            berr_n_q   <= 1'b1;
            ram_cs_n_q <= 1'b1;
            ram_we_n_q <= 2'b11;
            leds_q     <= 8'h00;
        end else begin
            // RAM strobes are single-clock pulses unless re-asserted below
            ram_cs_n_q <= 1'b1;
            ram_we_n_q <= 2'b11;

            case (state_q)
                S_IDLE: begin
                    if (!cpu_as_n) begin
                        berr_cnt_q <= 8'd1;
                        state_q    <= S_STROBE;
                    end
                end

                S_STROBE: begin
                    if (berr_cnt_q != C_BERR_T) begin
                        berr_cnt_q <= berr_cnt_q + 8'd1;
                    end
                    if (cpu_as_n) begin
                        state_q <= S_IDLE;
                    end else if (strobe) begin
                        if (ram_hit) begin
                            ram_cs_n_q <= 1'b0;
                            if (!cpu_rw) begin
                                ram_we_n_q <= {cpu_uds_n, cpu_lds_n};
                            end
                            ram_rd_q <= cpu_rw;
                            wait_q   <= C_RAM_LOAD;
                            state_q  <= S_WAIT;
                        end else if (led_hit) begin
                            if (!cpu_rw && !cpu_lds_n) begin
                                leds_q <= cpu_dout[7:0];
                            end
                            if (cpu_rw) begin
                                cpu_din_q <= {8'h00, leds_q};
                            end
                            ram_rd_q <= 1'b0;
                            wait_q   <= C_IO_LOAD;
                            state_q  <= S_WAIT;
                        end else begin
                            state_q <= S_BERR;
                            if (timeout) begin
                                berr_n_q  <= 1'b0;
                                cpu_din_q <= 16'hFFFF;
                            end
                        end
                    end else if (timeout) begin
                        // Strobes never arrived: treat as a hung cycle
                        berr_n_q  <= 1'b0;
                        cpu_din_q <= 16'hFFFF;
                        state_q   <= S_BERR;
                    end
                end

                S_WAIT: begin
                    if (cpu_as_n) begin
                        state_q <= S_IDLE;
                    end else if (wait_q == 4'd0) begin
                        if (ram_rd_q) begin
                            cpu_din_q <= ram_do;
                        end
                        dtack_n_q <= 1'b0;
                        state_q   <= S_ACK;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end

                S_ACK: begin
                    if (cpu_as_n) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end

                S_BERR: begin
                    if (berr_cnt_q != C_BERR_T) begin
                        berr_cnt_q <= berr_cnt_q + 8'd1;
                    end
                    if (cpu_as_n) begin
                        berr_n_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else if (timeout) begin
                        berr_n_q  <= 1'b0;
                        cpu_din_q <= 16'hFFFF;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_ctrl.sv
// ============================================================================
// Module   : tb_m68k_bus_ctrl
// Brief    : Self-checking bench for m68k_bus_ctrl. A cycle-count model of the
//            bus protocol predicts every registered output; directed checks
//            pin latencies, data values and the asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_m68k_bus_ctrl;

    localparam int          RAM_WAIT     = 1;
    localparam int          IO_WAIT      = 0;
    localparam int          BERR_TIMEOUT = 64;
    localparam logic [23:0] LED_A        = 24'hFF0000;
    localparam int          RAM_LAT      = ((RAM_WAIT == 0) ? 1 : RAM_WAIT) + 1;
    localparam int          IO_LAT       = IO_WAIT + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_as_n = 1'b1;
    logic        cpu_uds_n = 1'b1;
    logic        cpu_lds_n = 1'b1;
    logic        cpu_rw = 1'b1;
    logic [23:1] cpu_a = '0;
    logic [15:0] cpu_dout = '0;
    logic [15:0] cpu_din;
    logic        dtack_n;
    logic        berr_n;
    logic        ram_cs_n;
    logic [1:0]  ram_we_n;
    logic [11:0] ram_addr;
    logic [15:0] ram_di;
    logic [15:0] ram_do;
    logic [7:0]  leds;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    m68k_bus_ctrl #(
        .RAM_WAIT     (RAM_WAIT),
        .IO_WAIT      (IO_WAIT),
        .BERR_TIMEOUT (BERR_TIMEOUT),
        .LED_ADDR     (LED_A)
    ) dut (
        .clk_25mhz (clk),
        .reset     (reset),
        .cpu_as_n  (cpu_as_n),
        .cpu_uds_n (cpu_uds_n),
        .cpu_lds_n (cpu_lds_n),
        .cpu_rw    (cpu_rw),
        .cpu_a     (cpu_a),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .ram_cs_n  (ram_cs_n),
        .ram_we_n  (ram_we_n),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_do    (ram_do),
        .leds      (leds)
    );

    always #20 clk = ~clk;

    // External synchronous 4Kx16 RAM with byte write enables
    logic [15:0] ram_env [0:4095];
    initial begin
        logic [15:0] rd;
        for (int i = 0; i < 4096; i++) ram_env[i] = 16'h0000;
        ram_do = 16'h0000;
        forever begin
            @(posedge clk);
            if (!ram_cs_n) begin
                rd = ram_env[ram_addr];
                if (!ram_we_n[1]) ram_env[ram_addr][15:8] = ram_di[15:8];
                if (!ram_we_n[0]) ram_env[ram_addr][7:0]  = ram_di[7:0];
                ram_do <= rd;
            end
        end
    end

    // Protocol model: expected outputs from edge counts since AS was seen low
    logic [15:0] exp_din;
    logic        exp_dtack, exp_berr, exp_cs;
    logic [1:0]  exp_we;
    logic [7:0]  exp_leds;
    logic [11:0] exp_addr;
    logic [15:0] exp_di;
    logic [15:0] exp_mem [0:4095];
    initial begin
        bit   busy;
        int   n, s, lat;
        bit   is_ram, is_led, is_rd;
        logic [11:0] wa;
        for (int i = 0; i < 4096; i++) exp_mem[i] = 16'h0000;
        busy = 0; n = 0; s = -1; is_ram = 0; is_led = 0; is_rd = 0; wa = '0;
        exp_din = 0; exp_dtack = 1; exp_berr = 1; exp_cs = 1; exp_we = 2'b11;
        exp_leds = 0; exp_addr = '0; exp_di = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                busy = 0;
                exp_din = 0; exp_dtack = 1; exp_berr = 1; exp_cs = 1;
                exp_we = 2'b11; exp_leds = 0;
            end else begin
                exp_cs = 1;
                exp_we = 2'b11;
                if (!busy) begin
                    if (!cpu_as_n) begin
                        busy   = 1; n = 0; s = -1;
                        is_ram = (cpu_a[23:13] == 11'd0);
                        is_led = ({cpu_a, 1'b0} == LED_A);
                        is_rd  = cpu_rw;
                        wa     = cpu_a[12:1];
                    end
                end else begin
                    n++;
                    if (cpu_as_n) begin
                        busy = 0; exp_dtack = 1; exp_berr = 1;
                    end else begin
                        if (s < 0 && n <= BERR_TIMEOUT && (!cpu_uds_n || !cpu_lds_n)) begin
                            s = n;
                            if (is_ram) begin
                                exp_cs   = 0;
                                exp_addr = wa;
                                exp_di   = cpu_dout;
                                if (!is_rd) begin
                                    exp_we = {cpu_uds_n, cpu_lds_n};
                                    if (!cpu_uds_n) exp_mem[wa][15:8] = cpu_dout[15:8];
                                    if (!cpu_lds_n) exp_mem[wa][7:0]  = cpu_dout[7:0];
                                end
                            end else if (is_led) begin
                                if (is_rd) exp_din = {8'h00, exp_leds};
                                else if (!cpu_lds_n) exp_leds = cpu_dout[7:0];
                            end
                        end
                        if (s >= 0 && (is_ram || is_led)) begin
                            lat = is_ram ? RAM_LAT : IO_LAT;
                            if (n == s + lat) begin
                                exp_dtack = 0;
                                if (is_ram && is_rd) exp_din = exp_mem[wa];
                            end
                        end else if (n == BERR_TIMEOUT) begin
                            exp_berr = 0;
                            exp_din  = 16'hFFFF;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_din",  cpu_din,           exp_din);
            chk("dtack_n",  {15'd0, dtack_n},  {15'd0, exp_dtack});
            chk("berr_n",   {15'd0, berr_n},   {15'd0, exp_berr});
            chk("ram_cs_n", {15'd0, ram_cs_n}, {15'd0, exp_cs});
            chk("ram_we_n", {14'd0, ram_we_n}, {14'd0, exp_we});
            chk("leds",     {8'd0, leds},      {8'd0, exp_leds});
            if (!exp_cs) begin
                chk("ram_addr", {4'd0, ram_addr}, {4'd0, exp_addr});
                chk("ram_di",   ram_di,           exp_di);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    // One complete CPU bus cycle; returns edges from strobe to DTACK and read data
    task automatic bus_cycle(input logic [23:0] addr, input logic rw, input logic [15:0] wdata,
                             input logic uds_n, input logic lds_n,
                             output int lat_ticks, output logic [15:0] rdata);
        cpu_a = addr[23:1]; cpu_rw = rw; cpu_dout = wdata; cpu_as_n = 0;
        tick();
        cpu_uds_n = uds_n; cpu_lds_n = lds_n;
        lat_ticks = 0;
        while (dtack_n && lat_ticks < 20) begin
            tick();
            lat_ticks++;
        end
        chk("dtack_seen", {15'd0, dtack_n}, 16'd0);
        rdata = cpu_din;
        cpu_as_n = 1; cpu_uds_n = 1; cpu_lds_n = 1; cpu_rw = 1;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          lat, k;
        logic [15:0] rd;

        // Reset state
        repeat (3) tick();
        chk("rst_din",   cpu_din,            16'h0000);
        chk("rst_dtack", {15'd0, dtack_n},   16'd1);
        chk("rst_berr",  {15'd0, berr_n},    16'd1);
        chk("rst_cs",    {15'd0, ram_cs_n},  16'd1);
        chk("rst_we",    {14'd0, ram_we_n},  16'd3);
        chk("rst_leds",  {8'd0, leds},       16'd0);
        reset = 0;
        chk_en = 1;
        tick();

        // RAM word write then read
        bus_cycle(24'h000010, 1'b0, 16'h1234, 1'b0, 1'b0, lat, rd);
        chk("ram_wr_lat", 16'(lat), 16'd3);
        bus_cycle(24'h000010, 1'b1, 16'h0000, 1'b0, 1'b0, lat, rd);
        chk("ram_rd_lat",  16'(lat), 16'd3);
        chk("ram_rd_data", rd, 16'h1234);

        // Byte write to lower lane only
        bus_cycle(24'h000012, 1'b0, 16'h5566, 1'b0, 1'b0, lat, rd);
        bus_cycle(24'h000012, 1'b0, 16'hABCD, 1'b1, 1'b0, lat, rd);
        bus_cycle(24'h000012, 1'b1, 16'h0000, 1'b0, 1'b0, lat, rd);
        chk("byte_wr_data", rd, 16'h55CD);

        // LED register
        bus_cycle(LED_A, 1'b0, 16'h00A5, 1'b0, 1'b0, lat, rd);
        chk("led_wr_lat", 16'(lat), 16'd2);
        chk("led_val",    {8'd0, leds}, 16'h00A5);
        bus_cycle(LED_A, 1'b1, 16'h0000, 1'b0, 1'b0, lat, rd);
        chk("led_rd_lat",  16'(lat), 16'd2);
        chk("led_rd_data", rd, 16'h00A5);
        bus_cycle(LED_A, 1'b0, 16'h3C00, 1'b0, 1'b1, lat, rd);
        chk("led_uds_only", {8'd0, leds}, 16'h00A5);

        // Unmapped read: BERR after the timeout, released one clock after AS
        cpu_a = 23'(24'h400000 >> 1); cpu_rw = 1; cpu_as_n = 0;
        tick();
        cpu_uds_n = 0; cpu_lds_n = 0;
        k = 0;
        while (berr_n && k < 100) begin
            chk("unmap_no_dtack", {15'd0, dtack_n}, 16'd1);
            tick();
            k++;
        end
        chk("berr_latency", 16'(k), 16'(BERR_TIMEOUT));
        chk("berr_din",     cpu_din, 16'hFFFF);
        chk("berr_dtack",   {15'd0, dtack_n}, 16'd1);
        cpu_as_n = 1; cpu_uds_n = 1; cpu_lds_n = 1;
        tick();
        chk("berr_release", {15'd0, berr_n}, 16'd1);
        tick();

        // Mapped address with strobes that never arrive
        cpu_a = 23'(24'h000020 >> 1); cpu_rw = 1; cpu_as_n = 0;
        tick();
        k = 0;
        while (berr_n && k < 100) begin
            tick();
            k++;
        end
        chk("hung_latency", 16'(k), 16'(BERR_TIMEOUT));
        cpu_as_n = 1;
        tick();
        tick();

        // Aborted cycle before any strobe
        cpu_a = 23'(24'h000010 >> 1); cpu_rw = 1; cpu_as_n = 0;
        tick();
        tick();
        cpu_as_n = 1;
        tick();
        chk("abort_dtack", {15'd0, dtack_n}, 16'd1);
        chk("abort_cs",    {15'd0, ram_cs_n}, 16'd1);
        bus_cycle(24'h000010, 1'b1, 16'h0000, 1'b0, 1'b0, lat, rd);
        chk("post_abort_data", rd, 16'h1234);
        chk("post_abort_lat",  16'(lat), 16'd3);

        // Reset asserted while DTACK is held
        cpu_a = LED_A[23:1]; cpu_rw = 0; cpu_dout = 16'h005A; cpu_as_n = 0;
        tick();
        cpu_uds_n = 0; cpu_lds_n = 0;
        tick();
        tick();
        chk("pre_rst_dtack", {15'd0, dtack_n}, 16'd0);
        chk("pre_rst_leds",  {8'd0, leds},     16'h005A);
        #3;
        reset = 1;
        #1;
        chk("async_rst_dtack", {15'd0, dtack_n}, 16'd1);
        chk("async_rst_leds",  {8'd0, leds},     16'd0);
        chk("async_rst_din",   cpu_din,          16'h0000);
        cpu_as_n = 1; cpu_uds_n = 1; cpu_lds_n = 1; cpu_rw = 1;
        tick();
        tick();
        reset = 0;
        tick();
        bus_cycle(24'h000012, 1'b1, 16'h0000, 1'b0, 1'b0, lat, rd);
        chk("post_rst_data", rd, 16'h55CD);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
